// File: rtl/mem_initiator_pkg.sv
// Shared definitions for the memory bus initiator: bus widths, FSM state
// encoding and the timer terminal-count helper.
package mem_initiator_pkg;

    localparam int MEM_AW = 8;
    localparam int MEM_DW = 8;

    // Initiator FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RSP   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

    // A window of N cycles ends when the zero-based counter reaches N-1.
    function automatic logic [7:0] terminal_count(input logic [7:0] cycles);
        return cycles - 8'd1;
    endfunction

endpackage

// File: rtl/mem_initiator_if.sv
// Command/response port plus wait-state RAM bus of the memory initiator.
// master: the initiator view; slave: the command source / RAM responder view.
interface mem_initiator_if;
    import mem_initiator_pkg::*;

    // command port
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [MEM_AW-1:0] cmd_addr;
    logic [MEM_DW-1:0] cmd_wdata;
    // response port
    logic              rsp_valid;
    logic              rsp_ready;
    logic [MEM_DW-1:0] rsp_data;
    logic              rsp_write;
    logic              rsp_err;
    logic              busy;
    // RAM bus
    logic [MEM_AW-1:0] addr;
    logic              read;
    logic              write;
    logic [MEM_DW-1:0] writedata;
    logic              ready;
    logic [MEM_DW-1:0] readdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, ready, readdata,
        output cmd_ready, rsp_valid, rsp_data, rsp_write, rsp_err, busy,
               addr, read, write, writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready, ready, readdata,
        input  cmd_ready, rsp_valid, rsp_data, rsp_write, rsp_err, busy,
               addr, read, write, writedata
    );

endinterface

// File: rtl/mem_initiator_wait_timer.sv
// Clear/enable counter with a terminal-count flag. The counter saturates at
// the terminal value so it can never wrap back and re-arm an expired window.
module mem_initiator_wait_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_i,
    input  logic       enable_i,
    input  logic [7:0] terminal_i,
    output logic       tc_o
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    assign tc_o = (count_q == terminal_i);

    // Next count: clear wins, otherwise count up until terminal is reached
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = 8'd0;
        end else if (enable_i && !tc_o) begin
            count_d = count_q + 8'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_initiator.sv
// Bus initiator for the req/ready wait-state RAM. Takes one command at a time,
// holds read/write until ready is sampled, and hands back read data or write
// completion. Requests that never see ready are aborted by a wait timer; an
// abort is followed by a drain window in which late ready pulses are ignored.
// Every bus and response output is driven straight from a flop.
module mem_initiator
    import mem_initiator_pkg::*;
#(
    parameter logic [7:0] MAX_WAIT = 8'd16,
    parameter logic [2:0] DRAIN    = 3'd4
) (
    input  logic              clk,
    input  logic              reset,
    mem_initiator_if.master   bus
);

    state_e            state_q,     state_d;
    logic [MEM_AW-1:0] addr_q,      addr_d;
    logic              read_q,      read_d;
    logic              write_q,     write_d;
    logic [MEM_DW-1:0] wdata_q,     wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [MEM_DW-1:0] rsp_data_q,  rsp_data_d;
    logic              rsp_write_q, rsp_write_d;
    logic              rsp_err_q,   rsp_err_d;
    logic              drain_q,     drain_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q,      busy_d;

    logic              tmr_clear_s;
    logic              tmr_enable_s;
    logic [7:0]        tmr_terminal_s;
    logic              tmr_tc_s;

    // One timer serves both the request timeout and the post-abort drain;
    // it sits at zero in IDLE/RSP so it starts fresh on entry to REQ/DRAIN.
    always_comb begin
        tmr_clear_s    = (state_q == ST_IDLE) || (state_q == ST_RSP);
        tmr_enable_s   = (state_q == ST_REQ)  || (state_q == ST_DRAIN);
        if (state_q == ST_DRAIN) begin
            tmr_terminal_s = terminal_count({5'd0, DRAIN});
        end else begin
            tmr_terminal_s = terminal_count(MAX_WAIT);
        end
    end

    mem_initiator_wait_timer u_timer (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (tmr_clear_s),
        .enable_i   (tmr_enable_s),
        .terminal_i (tmr_terminal_s),
        .tc_o       (tmr_tc_s)
    );

    // Next-state and registered-output logic of the initiator FSM
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        read_d      = read_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_write_d = rsp_write_q;
        rsp_err_d   = rsp_err_q;
        drain_d     = drain_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.cmd_valid && cmd_ready_q) begin
                    addr_d      = bus.cmd_addr;
                    wdata_d     = bus.cmd_wdata;
                    read_d      = ~bus.cmd_write;
                    write_d     = bus.cmd_write;
                    rsp_write_d = bus.cmd_write;
                    state_d     = ST_REQ;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (bus.ready) begin
                    // readdata is only trusted here, and only for reads
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_data_d  = read_q ? bus.readdata : 8'h00;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    drain_d     = 1'b0;
                    state_d     = ST_RSP;
                end else if (tmr_tc_s) begin
                    read_d      = 1'b0;
                    write_d     = 1'b0;
                    rsp_data_d  = 8'h00;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    drain_d     = 1'b1;
                    state_d     = ST_RSP;
                end else begin
                    state_d     = ST_REQ;
                end
            end
            ST_RSP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    drain_d     = 1'b0;
                    if (drain_q && (DRAIN != 3'd0)) begin
                        state_d = ST_DRAIN;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d     = ST_RSP;
                end
            end
            ST_DRAIN: begin
                if (tmr_tc_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                read_d      = 1'b0;
                write_d     = 1'b0;
                rsp_valid_d = 1'b0;
                drain_d     = 1'b0;
            end
        endcase

        // cmd_ready/busy are registered copies of the next state
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
    end

    // State and output registers; reset drops any bus request immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= 8'h00;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            wdata_q     <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'h00;
            rsp_write_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            drain_q     <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            read_q      <= read_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_write_q <= rsp_write_d;
            rsp_err_q   <= rsp_err_d;
            drain_q     <= drain_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.addr      = addr_q;
    assign bus.read      = read_q;
    assign bus.write     = write_q;
    assign bus.writedata = wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_write = rsp_write_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Bench for mem_initiator paired with a behavioural wait-state RAM responder.
// Commands push their expected response into a queue; an independent monitor
// pops and compares on every response handshake.
module tb_mem_initiator;

    typedef struct {
        logic       w;
        logic [7:0] d;
        logic       e;
        int         acc;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    int         both_cnt = 0;
    exp_t       sb_q[$];

    logic [7:0] ws = 8'd0;
    logic       tie0 = 1'b0;
    logic [7:0] wcnt = 8'd0;
    logic [7:0] mem [256];

    mem_initiator_if bus_if();

    mem_initiator #(.MAX_WAIT(8'd8), .DRAIN(3'd4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM responder: ready after ws wait states, X on readdata otherwise
    assign bus_if.ready    = (bus_if.read | bus_if.write) && !tie0 && (wcnt == ws);
    assign bus_if.readdata = bus_if.ready ? mem[bus_if.addr] : 8'bx;

    always @(posedge clk) begin
        if (!(bus_if.read | bus_if.write) || bus_if.ready) wcnt <= 8'd0;
        else wcnt <= wcnt + 8'd1;
        if (bus_if.ready && bus_if.write) mem[bus_if.addr] <= bus_if.writedata;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on rsp_valid rise, contents on each response handshake
    initial begin : monitor
        logic prev_v;
        exp_t e;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_v = 1'b0;
            end else begin
                if (bus_if.read && bus_if.write) both_cnt++;
                if (bus_if.rsp_valid && !prev_v) begin
                    if (sb_q.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                    else chk("rsp_latency", cyc - sb_q[0].acc, sb_q[0].lat);
                end
                if (bus_if.rsp_valid && bus_if.rsp_ready && sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("rsp_data_known", {31'd0, $isunknown(bus_if.rsp_data)}, 32'd0);
                    chk("rsp_data", {24'd0, bus_if.rsp_data}, {24'd0, e.d});
                    chk("rsp_err", {31'd0, bus_if.rsp_err}, {31'd0, e.e});
                    chk("rsp_write", {31'd0, bus_if.rsp_write}, {31'd0, e.w});
                end
                prev_v = bus_if.rsp_valid;
            end
        end
    end

    // Offer one command, wait (bounded) for acceptance, push expectation
    task automatic issue(input logic w, input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] ed, input logic ee, input int lat,
                         input bit push, output int acc);
        int n;
        exp_t e;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_write = w;
        bus_if.cmd_addr  = a;
        bus_if.cmd_wdata = d;
        n = 0;
        while (!bus_if.cmd_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) begin
            chk("cmd_accept_timeout", 32'd1, 32'd0);
            acc = cyc;
            bus_if.cmd_valid = 1'b0;
        end else begin
            acc = cyc + 1;
            if (push) begin
                e.w = w; e.d = ed; e.e = ee; e.acc = acc; e.lat = lat;
                sb_q.push_back(e);
            end
            @(posedge clk); #1;
            bus_if.cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || !bus_if.cmd_ready) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_timeout", {31'd0, n < 200}, 32'd1);
    endtask

    initial begin : stim
        int a0, a1, a2, a3, n;
        int lat;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_write = 1'b0;
        bus_if.cmd_addr  = 8'h00;
        bus_if.cmd_wdata = 8'h00;
        bus_if.rsp_ready = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd1);
        chk("rst_busy",      {31'd0, bus_if.busy},      32'd0);
        chk("rst_read",      {31'd0, bus_if.read},      32'd0);
        chk("rst_write",     {31'd0, bus_if.write},     32'd0);
        chk("rst_addr",      {24'd0, bus_if.addr},      32'd0);
        chk("rst_writedata", {24'd0, bus_if.writedata}, 32'd0);
        chk("rst_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        chk("rst_rsp_err",   {31'd0, bus_if.rsp_err},   32'd0);
        chk("rst_rsp_write", {31'd0, bus_if.rsp_write}, 32'd0);
        chk("rst_rsp_data",  {24'd0, bus_if.rsp_data},  32'd0);
        chk("rst_known", {31'd0, $isunknown({bus_if.cmd_ready, bus_if.busy, bus_if.addr,
            bus_if.read, bus_if.write, bus_if.writedata, bus_if.rsp_valid,
            bus_if.rsp_data, bus_if.rsp_write, bus_if.rsp_err})}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int w = 0; w <= 4; w++) begin
            ws  = 8'(w);
            lat = w + 1;
            // write then read back
            issue(1'b1, 8'h34, 8'hA5, 8'h00, 1'b0, lat, 1'b1, a0);
            wait_done();
            issue(1'b0, 8'h34, 8'h00, 8'hA5, 1'b0, lat, 1'b1, a0);
            wait_done();
            // back-to-back stream with cmd_valid held high
            issue(1'b1, 8'h56, 8'h11, 8'h00, 1'b0, lat, 1'b1, a0);
            issue(1'b1, 8'h78, 8'h22, 8'h00, 1'b0, lat, 1'b1, a1);
            issue(1'b0, 8'h56, 8'h00, 8'h11, 1'b0, lat, 1'b1, a2);
            issue(1'b0, 8'h78, 8'h00, 8'h22, 1'b0, lat, 1'b1, a3);
            chk("tput_1", a1 - a0, w + 3);
            chk("tput_2", a2 - a1, w + 3);
            chk("tput_3", a3 - a2, w + 3);
            wait_done();
            // response back-pressure
            bus_if.rsp_ready = 1'b0;
            issue(1'b0, 8'h34, 8'h00, 8'hA5, 1'b0, lat, 1'b1, a0);
            n = 0;
            while (!bus_if.rsp_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
            chk("bp_rsp_seen", {31'd0, bus_if.rsp_valid}, 32'd1);
            for (int i = 0; i < 5; i++) begin
                chk("bp_rsp_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
                chk("bp_rsp_data",  {24'd0, bus_if.rsp_data},  32'h0000_00A5);
                chk("bp_cmd_ready", {31'd0, bus_if.cmd_ready}, 32'd0);
                chk("bp_bus_idle",  {31'd0, bus_if.read | bus_if.write}, 32'd0);
                @(posedge clk); #1;
            end
            bus_if.rsp_ready = 1'b1;
            wait_done();
        end

        // timeout abort and drain window
        ws   = 8'd0;
        tie0 = 1'b1;
        issue(1'b0, 8'h12, 8'h00, 8'h00, 1'b1, 8, 1'b1, a0);
        n = 0;
        while (!bus_if.cmd_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("abort_cmd_ready_gap", n, 32'd13);
        tie0 = 1'b0;
        wait_done();

        // reset in the middle of a request
        ws = 8'd3;
        issue(1'b1, 8'h9A, 8'h5C, 8'h00, 1'b0, 4, 1'b1, a0);
        wait_done();
        issue(1'b0, 8'h9A, 8'h00, 8'h00, 1'b0, 0, 1'b0, a0);
        chk("pre_rst_read", {31'd0, bus_if.read}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_read",  {31'd0, bus_if.read},      32'd0);
        chk("mid_rst_write", {31'd0, bus_if.write},     32'd0);
        chk("mid_rst_valid", {31'd0, bus_if.rsp_valid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.rsp_valid) n++;
            @(posedge clk); #1;
        end
        chk("post_rst_no_rsp", n, 32'd0);
        issue(1'b0, 8'h9A, 8'h00, 8'h5C, 1'b0, 4, 1'b1, a0);
        wait_done();

        chk("sb_empty", sb_q.size(), 32'd0);
        chk("read_write_both", both_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
